phase_measurement_controller: RTL and testbench



---
 rtl/phase_measurement_controller_if.sv | 43 ++++
 rtl/phase_measurement_controller.sv | 164 ++++++++++++++++
 tb/tb_phase_measurement_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_measurement_controller_if.sv
// Command, result and detector-side signals of the phase measurement controller.
// slave is the controller's view; master is the software/detector side.
interface phase_measurement_controller_if #(
  parameter int PHASE_COUNT_SIZE  = 6,
  parameter int CLK_0_COUNT_SIZE  = 6,
  parameter int SAMPLE_COUNT_SIZE = 8
);
  localparam int FW = PHASE_COUNT_SIZE + 3;
  localparam int AW = FW + SAMPLE_COUNT_SIZE;
  localparam int TW = CLK_0_COUNT_SIZE + PHASE_COUNT_SIZE + 4;

  logic                         cmd_start;
  logic [SAMPLE_COUNT_SIZE-1:0] cmd_num_samples;
  logic                         cmd_abort;
  logic                         cmd_ready;
  logic                         busy;
  logic                         det_rst;
  logic [TW-1:0]                phase_tag;
  logic                         phase_tag_valid;
  logic                         result_valid;
  logic                         result_ready;
  logic [AW-1:0]                result_sum;
  logic [FW-1:0]                result_min;
  logic [FW-1:0]                result_max;
  logic [SAMPLE_COUNT_SIZE-1:0] result_count;
  logic [1:0]                   result_status;

  modport slave (
    input  cmd_start, cmd_num_samples, cmd_abort,
    input  phase_tag, phase_tag_valid, result_ready,
    output cmd_ready, busy, det_rst, result_valid,
    output result_sum, result_min, result_max,
    output result_count, result_status
  );

  modport master (
    output cmd_start, cmd_num_samples, cmd_abort,
    output phase_tag, phase_tag_valid, result_ready,
    input  cmd_ready, busy, det_rst, result_valid,
    input  result_sum, result_min, result_max,
    input  result_count, result_status
  );
endinterface

// File: rtl/phase_measurement_controller.sv
// Runs the phase detector through one N-sample measurement and
// returns sum/min/max of the decoded fine phase values.
module phase_measurement_controller #(
  parameter int PHASE_COUNT_SIZE  = 6,
  parameter int CLK_0_COUNT_SIZE  = 6,
  parameter int SAMPLE_COUNT_SIZE = 8,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int FLUSH_CYCLES      = 4
) (
  input logic clk_0,
  input logic rst,
  phase_measurement_controller_if.slave bus
);
  localparam int P   = PHASE_COUNT_SIZE;
  localparam int C   = CLK_0_COUNT_SIZE;
  localparam int S   = SAMPLE_COUNT_SIZE;
  localparam int FW  = P + 3;
  localparam int AW  = FW + S;
  localparam int TW  = C + P + 4;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FLUSH_CYCLES - 1);

  localparam logic [FW-1:0] F_POS = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0] F_NEG = {1'b1, {(FW-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_DISC  = 3'd2;
  localparam logic [2:0] S_ACQ   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  logic [2:0]            state_q;
  logic [FCW-1:0]        fcnt_q;
  logic [TCW-1:0]        tcnt_q;
  logic [S-1:0]          n_q;
  logic [S-1:0]          cnt_q;
  logic [S-1:0]          cnt_nxt;
  logic signed [AW-1:0]  sum_q;
  logic signed [FW-1:0]  min_q;
  logic signed [FW-1:0]  max_q;
  logic [1:0]            status_q;

  logic [P-1:0]          coarse;
  logic [1:0]            sph;
  logic [1:0]            eph;
  logic signed [FW-1:0]  fine;
  logic [AW-1:0]         fine_x;
  logic                  unused_start;

  // start_count carries no information for the fine phase
  assign unused_start = ^bus.phase_tag[TW-1:TW-C];

  assign coarse = bus.phase_tag[P+3:4];
  assign sph    = bus.phase_tag[3:2];
  assign eph    = bus.phase_tag[1:0];

  assign fine = $signed({1'b0, coarse, 2'b00})
              + $signed({{(FW-2){1'b0}}, sph})
              - $signed({{(FW-2){1'b0}}, eph});

  assign fine_x  = {{S{fine[FW-1]}}, fine};
  assign cnt_nxt = cnt_q + 1'b1;

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      tcnt_q   <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      min_q    <= F_POS;
      max_q    <= F_NEG;
      status_q <= ST_OK;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_start) begin
            n_q      <= bus.cmd_num_samples;
            cnt_q    <= '0;
            sum_q    <= '0;
            fcnt_q   <= '0;
            tcnt_q   <= '0;
            min_q    <= F_POS;
            max_q    <= F_NEG;
            status_q <= ST_OK;
            if (bus.cmd_num_samples == '0) state_q <= S_DONE;
            else                           state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (bus.cmd_abort) begin
            state_q  <= S_DONE;
            status_q <= ST_ABORT;
          end else if (fcnt_q == F_LAST) begin
            state_q <= S_DISC;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        S_DISC: begin
          if (bus.cmd_abort) begin
            state_q  <= S_DONE;
            status_q <= ST_ABORT;
          end else if (bus.phase_tag_valid) begin
            tcnt_q  <= '0;
            state_q <= S_ACQ;
          end else if (tcnt_q == T_LAST) begin
            state_q  <= S_DONE;
            status_q <= ST_TMO;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_ACQ: begin
          if (bus.cmd_abort) begin
            state_q  <= S_DONE;
            status_q <= ST_ABORT;
          end else if (bus.phase_tag_valid) begin
            sum_q  <= sum_q + fine_x;
            cnt_q  <= cnt_nxt;
            tcnt_q <= '0;
            if (fine < min_q) min_q <= fine;
            if (fine > max_q) max_q <= fine;
            if (cnt_nxt == n_q) begin
              state_q  <= S_DONE;
              status_q <= ST_OK;
            end
          end else if (tcnt_q == T_LAST) begin
            state_q  <= S_DONE;
            status_q <= ST_TMO;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.result_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q == S_FLUSH)
                          || (state_q == S_DISC)
                          || (state_q == S_ACQ);
  assign bus.det_rst       = !((state_q == S_DISC)
                          ||   (state_q == S_ACQ));
  assign bus.result_valid  = (state_q == S_DONE);
  assign bus.result_sum    = sum_q;
  // sentinels are meaningless without samples
  assign bus.result_min    = (cnt_q == '0) ? '0 : min_q;
  assign bus.result_max    = (cnt_q == '0) ? '0 : max_q;
  assign bus.result_count  = cnt_q;
  assign bus.result_status = status_q;
endmodule

// File: tb/tb_phase_measurement_controller.sv
// Randomised and directed runs of the phase measurement controller
// against a run-level reference model.
module tb_phase_measurement_controller;
  localparam int P  = 6;
  localparam int C  = 6;
  localparam int S  = 8;
  localparam int TO = 16;
  localparam int FL = 4;

  logic clk_0 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_0 = ~clk_0;

  phase_measurement_controller_if #(
    .PHASE_COUNT_SIZE (P),
    .CLK_0_COUNT_SIZE (C),
    .SAMPLE_COUNT_SIZE(S)
  ) bus ();

  phase_measurement_controller #(
    .PHASE_COUNT_SIZE (P),
    .CLK_0_COUNT_SIZE (C),
    .SAMPLE_COUNT_SIZE(S),
    .TIMEOUT_CYCLES   (TO),
    .FLUSH_CYCLES     (FL)
  ) dut (
    .clk_0(clk_0),
    .rst  (rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int          gap_q[$];
  logic [15:0] tag_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fine_of(input logic [15:0] t);
    return 4 * int'(t[9:4]) + int'(t[3:2]) - int'(t[1:0]);
  endfunction

  function automatic logic [15:0] mk(input int c, input int s,
                                     input int e);
    logic [5:0] cc;
    logic [1:0] ss;
    logic [1:0] ee;
    logic [5:0] sc;
    cc = 6'(c);
    ss = 2'(s);
    ee = 2'(e);
    sc = 6'($urandom);
    return {sc, cc, ss, ee};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"},  int'(bus.cmd_ready), 1);
    chk({tag, "_vld"},  int'(bus.result_valid), 0);
    chk({tag, "_drst"}, int'(bus.det_rst), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic run_case(input string nm, input int n,
                          input int abort_idx, input int hold);
    int pos, done, st, cnt, sum, mn, mx, f, k;
    int tag_at[$];
    int flush_bad, early, bad;
    pos = -1; done = -1; st = 1;
    cnt = 0; sum = 0; mn = 0; mx = 0;
    for (int i = 0; i < tag_q.size(); i++) begin
      if (gap_q[i] >= TO) begin
        done = pos + TO + 1;
        break;
      end
      pos += 1 + gap_q[i];
      tag_at.push_back(pos);
      if (i == abort_idx) begin
        st = 2;
        done = pos + 1;
        break;
      end
      if (i > 0) begin
        f = fine_of(tag_q[i]);
        if (cnt == 0 || f < mn) mn = f;
        if (cnt == 0 || f > mx) mx = f;
        sum += f;
        cnt++;
        if (cnt == n) begin
          st = 0;
          done = pos + 1;
          break;
        end
      end
    end
    if (done < 0) done = pos + TO + 1;

    chk({nm, "_ready"}, int'(bus.cmd_ready), 1);
    bus.cmd_start       = 1'b1;
    bus.cmd_num_samples = S'(n);
    @(negedge clk_0);
    bus.cmd_start = 1'b0;
    flush_bad = 0;
    for (int i = 0; i < FL; i++) begin
      if (!bus.det_rst || !bus.busy || bus.cmd_ready) flush_bad++;
      @(negedge clk_0);
    end
    chk({nm, "_flush"}, flush_bad, 0);
    chk({nm, "_drst_lo"}, int'(bus.det_rst), 0);

    k = 0;
    early = 0;
    for (int t = 0; t < done; t++) begin
      if (bus.result_valid) early++;
      bus.phase_tag_valid = 1'b0;
      bus.cmd_abort       = 1'b0;
      if (k < tag_at.size() && tag_at[k] == t) begin
        bus.phase_tag       = tag_q[k];
        bus.phase_tag_valid = 1'b1;
        if (k == abort_idx) bus.cmd_abort = 1'b1;
        k++;
      end
      @(negedge clk_0);
    end
    bus.phase_tag_valid = 1'b0;
    bus.cmd_abort       = 1'b0;
    chk({nm, "_early"}, early, 0);
    chk({nm, "_valid"}, int'(bus.result_valid), 1);
    chk({nm, "_status"}, int'(bus.result_status), st);
    chk({nm, "_count"}, int'(bus.result_count), cnt);
    chk({nm, "_sum"}, int'($signed(bus.result_sum)), sum);
    chk({nm, "_min"}, int'($signed(bus.result_min)), mn);
    chk({nm, "_max"}, int'($signed(bus.result_max)), mx);

    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_0);
      if (!bus.result_valid) bad++;
      if (int'($signed(bus.result_sum)) != sum) bad++;
      if (int'($signed(bus.result_min)) != mn) bad++;
      if (int'($signed(bus.result_max)) != mx) bad++;
      if (int'(bus.result_count) != cnt) bad++;
      if (int'(bus.result_status) != st) bad++;
    end
    chk({nm, "_hold"}, bad, 0);
    bus.result_ready = 1'b1;
    @(negedge clk_0);
    bus.result_ready = 1'b0;
    chk_idle({nm, "_ret"});
  endtask

  initial begin
    bus.cmd_start       = 1'b0;
    bus.cmd_num_samples = '0;
    bus.cmd_abort       = 1'b0;
    bus.phase_tag       = '0;
    bus.phase_tag_valid = 1'b0;
    bus.result_ready    = 1'b0;
    rst = 1'b1;
    @(negedge clk_0);
    chk_idle("reset");
    chk("reset_sum", int'(bus.result_sum), 0);
    chk("reset_cnt", int'(bus.result_count), 0);
    @(negedge clk_0);
    rst = 1'b0;
    @(negedge clk_0);

    gap_q = '{0, 0, 1, 0};
    tag_q = '{mk(5, 0, 0), mk(10, 1, 3), mk(12, 0, 0), mk(11, 2, 1)};
    run_case("normal", 3, -1, 20);

    gap_q = '{2, 0};
    tag_q = '{mk(9, 1, 1), mk(0, 0, 3)};
    run_case("neg", 1, -1, 0);

    gap_q = '{0, 3};
    tag_q = '{mk(1, 0, 0), mk(7, 3, 0)};
    run_case("tmo", 4, -1, 0);

    gap_q = '{0, 0, 15, 0};
    tag_q = '{mk(2, 0, 0), mk(63, 3, 0), mk(4, 0, 2), mk(8, 1, 1)};
    run_case("abort", 3, 2, 0);

    gap_q = '{0, 15, 15};
    tag_q = '{mk(2, 0, 0), mk(63, 3, 0), mk(0, 0, 3)};
    run_case("edge15", 2, -1, 0);

    bus.cmd_start       = 1'b1;
    bus.cmd_num_samples = '0;
    @(negedge clk_0);
    bus.cmd_start = 1'b0;
    chk("zero_valid", int'(bus.result_valid), 1);
    chk("zero_drst", int'(bus.det_rst), 1);
    chk("zero_status", int'(bus.result_status), 0);
    chk("zero_sum", int'(bus.result_sum), 0);
    chk("zero_min", int'(bus.result_min), 0);
    chk("zero_max", int'(bus.result_max), 0);
    chk("zero_cnt", int'(bus.result_count), 0);
    bus.result_ready = 1'b1;
    @(negedge clk_0);
    bus.result_ready = 1'b0;
    chk_idle("zero_ret");

    bus.cmd_start       = 1'b1;
    bus.cmd_num_samples = 8'd5;
    @(negedge clk_0);
    bus.cmd_start = 1'b0;
    repeat (FL) @(negedge clk_0);
    for (int i = 0; i < 2; i++) begin
      bus.phase_tag       = mk(20 + i, 1, 0);
      bus.phase_tag_valid = 1'b1;
      @(negedge clk_0);
    end
    bus.phase_tag_valid = 1'b0;
    chk("mid_cnt", int'(bus.result_count), 1);
    chk("mid_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk_0);
    rst = 1'b0;
    chk_idle("midrst");
    chk("midrst_sum", int'(bus.result_sum), 0);
    chk("midrst_cnt", int'(bus.result_count), 0);
    chk("midrst_min", int'(bus.result_min), 0);
    chk("midrst_max", int'(bus.result_max), 0);
    chk("midrst_st", int'(bus.result_status), 0);

    for (int r = 0; r < 40; r++) begin
      int n, nt, ab;
      n  = $urandom_range(1, 6);
      nt = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n) : n + 1;
      gap_q.delete();
      tag_q.delete();
      for (int i = 0; i < nt; i++) begin
        if ($urandom_range(0, 9) == 0) gap_q.push_back($urandom_range(14, 18));
        else                           gap_q.push_back($urandom_range(0, 4));
        tag_q.push_back(16'($urandom));
      end
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nt - 1) : -1;
      run_case("rand", n, ab, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
